// File: rtl/merge_pkg.sv
// merge_pkg: shared flit type, default width and merge FSM states
package merge_pkg;
  localparam int FLIT_W = 11;
  typedef logic [FLIT_W-1:0] flit_t;
  typedef enum logic {IDLE, LOCKED} merge_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr; ports req/ptr in, gnt (one-hot)/gnt_idx/any out
module rr_arbiter #(
  parameter int N = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] c;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IW'((int'(ptr) + k) % N);
      if (req[c]) begin
        gnt_idx = c;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/merge_rr_fifo.sv
// merge_rr_fifo: N_IN-input round-robin merge with optional wormhole lock into a DEPTH-entry FIFO; flit ports in_valid/in_data/in_ready, out_valid/out_data/out_ready, debug grant_idx/count
module merge_rr_fifo
  import merge_pkg::*;
#(
  parameter int N_IN = 5,
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4,
  parameter int PKT_FLITS = 1,
  localparam int IW = $clog2(N_IN),
  localparam int AW = $clog2(DEPTH),
  localparam int FW = $clog2(PKT_FLITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [IW-1:0]         grant_idx,
  output logic [AW:0]           count
);
  merge_state_e state_q;
  logic [IW-1:0] lock_q, rr_q, grant_q, gnt_idx;
  logic [FW-1:0] flit_cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [N_IN-1:0] req, gnt;
  logic any, full, push, pop;
  // while locked only the packet owner may compete
  assign req = (state_q == LOCKED) ? in_valid & (N_IN'(1) << lock_q) : in_valid;
  rr_arbiter #(.N(N_IN)) u_arb (
    .req(req),
    .ptr(rr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  // a same-cycle pop never frees a slot for the push
  assign full = count_q == (AW + 1)'(DEPTH);
  assign in_ready = full ? '0 : gnt;
  assign push = any & ~full;
  assign pop = out_valid & out_ready;
  assign count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  assign out_valid = count_q != '0;
  assign out_data = mem_q[rd_q];
  assign grant_idx = grant_q;
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q <= '0;
      rr_q <= '0;
      grant_q <= '0;
      flit_cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= (gnt_idx == IW'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
        grant_q <= gnt_idx;
        if (PKT_FLITS > 1) begin
          if (state_q == IDLE) begin
            state_q <= LOCKED;
            lock_q <= gnt_idx;
            flit_cnt_q <= FW'(1);
          end else if (flit_cnt_q == FW'(PKT_FLITS - 1)) begin
            state_q <= IDLE;
            flit_cnt_q <= '0;
          end else begin
            flit_cnt_q <= flit_cnt_q + 1'b1;
          end
        end
      end
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data[gnt_idx*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_merge_rr_fifo.sv
// tb_merge_rr_fifo: per-flit and wormhole merges driven together and checked against a packet-level reference model
module tb_merge_rr_fifo;
  localparam int N = 5;
  localparam int W = 11;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [N-1:0] in_ready [2];
  logic out_valid [2];
  logic [W-1:0] out_data [2];
  logic [2:0] grant_idx [2];
  logic [2:0] count [2];
  merge_rr_fifo #(.N_IN(N), .WIDTH(W), .DEPTH(D), .PKT_FLITS(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready),
    .grant_idx(grant_idx[0]), .count(count[0])
  );
  merge_rr_fifo #(.N_IN(N), .WIDTH(W), .DEPTH(D), .PKT_FLITS(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready),
    .grant_idx(grant_idx[1]), .count(count[1])
  );
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  bit started = 0;
  int rr [2], gidx [2], mcount [2], rem [2];
  bit locked [2];
  int lock [2];
  logic [W-1:0] exp_q [2][$];
  function automatic int pkt(int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic int pick(int k);
    for (int o = 0; o < N; o++) begin
      int i = (rr[k] + o) % N;
      if (in_valid[i] && (!locked[k] || i == lock[k])) return i;
    end
    return -1;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      bit pop;
      if (reset) begin
        rr[k] = 0; gidx[k] = 0; mcount[k] = 0; rem[k] = 0; locked[k] = 0; lock[k] = 0;
        exp_q[k].delete();
      end else begin
        pop = mcount[k] != 0 && out_ready;
        g = pick(k);
        if (g >= 0 && mcount[k] < D) begin
          exp_q[k].push_back(in_data[g*W +: W]);
          rr[k] = (g + 1) % N;
          gidx[k] = g;
          mcount[k]++;
          if (locked[k]) begin
            rem[k]--;
            if (rem[k] == 0) locked[k] = 0;
          end else if (pkt(k) > 1) begin
            locked[k] = 1; lock[k] = g; rem[k] = pkt(k) - 1;
          end
        end
        if (pop) mcount[k]--;
      end
    end
    if (reset) started = 1;
  end
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int g;
        int er;
        g = pick(k);
        er = (g >= 0 && mcount[k] < D) ? (1 << g) : 0;
        chk($sformatf("count%0d", k), int'(count[k]), mcount[k]);
        chk($sformatf("out_valid%0d", k), int'(out_valid[k]), int'(mcount[k] != 0));
        chk($sformatf("grant_idx%0d", k), int'(grant_idx[k]), gidx[k]);
        chk($sformatf("in_ready%0d", k), int'(in_ready[k]), er);
        if (!reset && out_valid[k] && out_ready) begin
          if (exp_q[k].size() == 0) chk($sformatf("unexpected_out%0d", k), int'(out_data[k]), -1);
          else chk($sformatf("out_data%0d", k), int'(out_data[k]), int'(exp_q[k].pop_front()));
        end
      end
    end
  end
  initial begin
    int t;
    bit acc;
    logic [W-1:0] d;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(11'h100 + i);
    in_valid = '1;
    out_ready = 1'b1;
    cyc(20);
    in_valid = '0;
    cyc(6);
    out_ready = 1'b0;
    d = 11'h7A0;
    in_data[2*W +: W] = d;
    in_valid = 5'b00100;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      acc = in_ready[0][2];
      cyc(1);
      if (acc) begin d = d + 1'b1; in_data[2*W +: W] = d; end
    end
    chk("full_count", int'(count[0]), D);
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      acc = in_ready[0][2];
      cyc(1);
      if (acc) begin d = d + 1'b1; in_data[2*W +: W] = d; end
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    in_data[1*W +: W] = 11'h111;
    in_data[3*W +: W] = 11'h333;
    in_valid = 5'b01010;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready[1][1] && t < 20);
    chk("t4_wait", int'(t < 20), 1);
    cyc(1);
    in_valid[1] = 1'b0;
    in_data[1*W +: W] = 11'h112;
    cyc(2);
    in_valid[1] = 1'b1;
    cyc(12);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    out_ready = 1'b0;
    in_data[0*W +: W] = 11'h0AA;
    in_valid = 5'b00001;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    in_valid = '1;
    out_ready = 1'b1;
    cyc(6);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    out_ready = 1'b0;
    in_valid = 5'b00100;
    cyc(6);
    out_ready = 1'b1;
    cyc(4);
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 150) == 0;
      in_valid = N'($urandom);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      out_ready = ($urandom % 4) != 0;
      cyc(1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
